reg_rd_arb: RTL and testbench

REG_RD_ARB -- requirements
Module: reg_rd_arb

---
 rtl/cpu15_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/reg_rd_arb.sv | 155 +++++++++++++++
 tb/tb_reg_rd_arb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu15_pkg.sv
// Shared definitions for the register-read arbiter: FSM state encodings,
// requester owner codes and the saturating hazard counter helper.
package cpu15_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HAZ   = 3'd1,
    ST_SEL   = 3'd2,
    ST_WAITD = 3'd3,
    ST_CAPT  = 3'd4
  } state_e;

  localparam logic OWN_DC  = 1'b0;
  localparam logic OWN_MON = 1'b1;

  localparam logic [7:0] HAZ_CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == HAZ_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the decode and monitor requesters.
// The priority pointer only moves when a grant is actually issued.
module rr_arb2 import cpu15_pkg::*; (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_dc_i,
  input  logic req_mon_i,
  input  logic upd_i,
  input  logic upd_own_i,
  output logic vld_o,
  output logic win_o
);

  // prio_q names the requester that wins a tie; the one just granted loses it
  logic prio_q;
  logic prio_d;

  always_comb begin
    vld_o = req_dc_i | req_mon_i;
    if (req_dc_i && req_mon_i) begin
      win_o = prio_q;
    end else if (req_mon_i) begin
      win_o = OWN_MON;
    end else begin
      win_o = OWN_DC;
    end
    prio_d = prio_q;
    if (upd_i) begin
      prio_d = ~upd_own_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_q <= OWN_DC;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/reg_rd_arb.sv
// Register-file read arbiter: picks decode or monitor, stalls on a pending
// write-back to the same register, drives the mux select and captures the data.
module reg_rd_arb import cpu15_pkg::*; #(
  parameter int unsigned MUX_LAT = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_dc_i,
  input  logic [2:0]  n_reg_dc_i,
  input  logic        req_mon_i,
  input  logic [2:0]  n_reg_mon_i,
  input  logic        wb_pend_i,
  input  logic [2:0]  n_reg_wb_i,
  input  logic        wb_done_i,
  input  logic [15:0] reg_data_i,
  output logic [2:0]  n_reg_sel_o,
  output logic        gnt_dc_o,
  output logic        gnt_mon_o,
  output logic [15:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        rd_owner_o,
  output logic        busy_o,
  output logic [7:0]  haz_cnt_o
);

  localparam logic [1:0] WAIT_INIT = 2'(MUX_LAT - 1);

  state_e      state_q;
  logic        winner_q;
  logic [2:0]  reg_q;
  logic [1:0]  wcnt_q;
  logic [2:0]  n_reg_sel_q;
  logic        gnt_dc_q;
  logic        gnt_mon_q;
  logic [15:0] rd_data_q;
  logic        rd_valid_q;
  logic        rd_owner_q;
  logic        busy_q;
  logic [7:0]  haz_cnt_q;

  logic        arb_vld;
  logic        arb_win;
  logic [2:0]  win_reg;
  logic        hazard;
  logic        haz_exit;
  logic        lock_req;
  logic        arb_upd;
  logic        arb_upd_own;
  logic        arb_state;

  // A write-back finishing in the selection cycle already clears the hazard
  always_comb begin
    arb_state   = (state_q == ST_IDLE) || (state_q == ST_CAPT);
    win_reg     = (arb_win == OWN_MON) ? n_reg_mon_i : n_reg_dc_i;
    hazard      = (win_reg == n_reg_wb_i) && wb_pend_i && !wb_done_i;
    haz_exit    = wb_done_i || !wb_pend_i;
    lock_req    = (winner_q == OWN_MON) ? req_mon_i : req_dc_i;
    arb_upd     = (arb_state && arb_vld && !hazard) ||
                  ((state_q == ST_HAZ) && haz_exit && lock_req);
    arb_upd_own = (state_q == ST_HAZ) ? winner_q : arb_win;
  end

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_dc_i  (req_dc_i),
    .req_mon_i (req_mon_i),
    .upd_i     (arb_upd),
    .upd_own_i (arb_upd_own),
    .vld_o     (arb_vld),
    .win_o     (arb_win)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      winner_q    <= OWN_DC;
      reg_q       <= 3'd0;
      wcnt_q      <= 2'd0;
      n_reg_sel_q <= 3'd0;
      gnt_dc_q    <= 1'b0;
      gnt_mon_q   <= 1'b0;
      rd_data_q   <= 16'h0000;
      rd_valid_q  <= 1'b0;
      rd_owner_q  <= OWN_DC;
      busy_q      <= 1'b0;
      haz_cnt_q   <= 8'd0;
    end else begin
      gnt_dc_q   <= 1'b0;
      gnt_mon_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_CAPT: begin
          if (state_q == ST_CAPT) begin
            rd_data_q  <= reg_data_i;
            rd_owner_q <= winner_q;
            rd_valid_q <= 1'b1;
          end
          if (arb_vld) begin
            winner_q <= arb_win;
            reg_q    <= win_reg;
            busy_q   <= 1'b1;
            if (hazard) begin
              state_q <= ST_HAZ;
            end else begin
              state_q     <= ST_SEL;
              n_reg_sel_q <= win_reg;
              gnt_dc_q    <= (arb_win == OWN_DC);
              gnt_mon_q   <= (arb_win == OWN_MON);
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        // The locked read completes even if its requester has dropped away,
        // but a grant pulse is only given to a requester that is still asking
        ST_HAZ: begin
          haz_cnt_q <= sat_inc8(haz_cnt_q);
          if (haz_exit) begin
            state_q     <= ST_SEL;
            n_reg_sel_q <= reg_q;
            gnt_dc_q    <= (winner_q == OWN_DC) && req_dc_i;
            gnt_mon_q   <= (winner_q == OWN_MON) && req_mon_i;
          end
        end
        ST_SEL: begin
          state_q <= ST_WAITD;
          wcnt_q  <= WAIT_INIT;
        end
        ST_WAITD: begin
          if (wcnt_q == 2'd0) begin
            state_q <= ST_CAPT;
          end else begin
            wcnt_q <= wcnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign n_reg_sel_o = n_reg_sel_q;
  assign gnt_dc_o    = gnt_dc_q;
  assign gnt_mon_o   = gnt_mon_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_owner_o  = rd_owner_q;
  assign busy_o      = busy_q;
  assign haz_cnt_o   = haz_cnt_q;

endmodule

// File: tb/tb_reg_rd_arb.sv
// Directed bench for reg_rd_arb: one instance with MUX_LAT=1 and one with
// MUX_LAT=3 share the same stimulus; expected values are hand-computed.
module tb_reg_rd_arb;

  logic        clk;
  logic        reset;
  logic        reqDc;
  logic [2:0]  nRegDc;
  logic        reqMon;
  logic [2:0]  nRegMon;
  logic        wbPend;
  logic [2:0]  nRegWb;
  logic        wbDone;
  logic [15:0] regData;

  logic [2:0]  nRegSel1, nRegSel3;
  logic        gntDc1, gntDc3;
  logic        gntMon1, gntMon3;
  logic [15:0] rdData1, rdData3;
  logic        rdValid1, rdValid3;
  logic        rdOwner1, rdOwner3;
  logic        busy1, busy3;
  logic [7:0]  hazCnt1, hazCnt3;

  int assertCount = 0;
  int failCount   = 0;

  reg_rd_arb #(.MUX_LAT(1)) dut1 (
    .clk_i(clk), .reset_i(reset),
    .req_dc_i(reqDc), .n_reg_dc_i(nRegDc),
    .req_mon_i(reqMon), .n_reg_mon_i(nRegMon),
    .wb_pend_i(wbPend), .n_reg_wb_i(nRegWb), .wb_done_i(wbDone),
    .reg_data_i(regData),
    .n_reg_sel_o(nRegSel1), .gnt_dc_o(gntDc1), .gnt_mon_o(gntMon1),
    .rd_data_o(rdData1), .rd_valid_o(rdValid1), .rd_owner_o(rdOwner1),
    .busy_o(busy1), .haz_cnt_o(hazCnt1)
  );

  reg_rd_arb #(.MUX_LAT(3)) dut3 (
    .clk_i(clk), .reset_i(reset),
    .req_dc_i(reqDc), .n_reg_dc_i(nRegDc),
    .req_mon_i(reqMon), .n_reg_mon_i(nRegMon),
    .wb_pend_i(wbPend), .n_reg_wb_i(nRegWb), .wb_done_i(wbDone),
    .reg_data_i(regData),
    .n_reg_sel_o(nRegSel3), .gnt_dc_o(gntDc3), .gnt_mon_o(gntMon3),
    .rd_data_o(rdData3), .rd_valid_o(rdValid3), .rd_owner_o(rdOwner3),
    .busy_o(busy3), .haz_cnt_o(hazCnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit so outputs are sampled off the edge
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reqDc = 1'b0; nRegDc = 3'd0; reqMon = 1'b0; nRegMon = 3'd0;
    wbPend = 1'b0; nRegWb = 3'd0; wbDone = 1'b0; regData = 16'h0000;

    $display("[TB] reset state");
    applyReset();
    checkOutput("rst_busy", {15'd0, busy1}, 16'd0);
    checkOutput("rst_valid", {15'd0, rdValid1}, 16'd0);
    checkOutput("rst_gnt", {14'd0, gntDc1, gntMon1}, 16'd0);
    checkOutput("rst_data", rdData1, 16'h0000);
    checkOutput("rst_hazcnt", {8'd0, hazCnt1}, 16'd0);
    checkOutput("rst_sel", {13'd0, nRegSel1}, 16'd0);

    $display("[TB] single DC read, MUX_LAT=1");
    reqDc = 1'b1; nRegDc = 3'd3; regData = 16'h1234;
    applyStimulus(1);
    checkOutput("dc_gnt_t1", {14'd0, gntDc1, gntMon1}, 16'b10);
    checkOutput("dc_sel_t1", {13'd0, nRegSel1}, 16'd3);
    checkOutput("dc_busy_t1", {15'd0, busy1}, 16'd1);
    reqDc = 1'b0;
    applyStimulus(1);
    checkOutput("dc_gnt_t2", {14'd0, gntDc1, gntMon1}, 16'b00);
    applyStimulus(1);
    checkOutput("dc_valid_t3", {15'd0, rdValid1}, 16'd0);
    applyStimulus(1);
    checkOutput("dc_valid_t4", {15'd0, rdValid1}, 16'd1);
    checkOutput("dc_data_t4", rdData1, 16'h1234);
    checkOutput("dc_owner_t4", {15'd0, rdOwner1}, 16'd0);
    checkOutput("dc_sel_hold", {13'd0, nRegSel1}, 16'd3);
    applyStimulus(1);
    checkOutput("dc_valid_t5", {15'd0, rdValid1}, 16'd0);
    checkOutput("dc_idle_busy", {15'd0, busy1}, 16'd0);

    $display("[TB] both requesters held, round robin");
    applyReset();
    reqDc = 1'b1; nRegDc = 3'd1; reqMon = 1'b1; nRegMon = 3'd2; regData = 16'h00A5;
    applyStimulus(1);
    checkOutput("rr_g1", {14'd0, gntDc1, gntMon1}, 16'b10);
    checkOutput("rr_sel1", {13'd0, nRegSel1}, 16'd1);
    applyStimulus(1);
    checkOutput("rr_gap2", {14'd0, gntDc1, gntMon1}, 16'b00);
    applyStimulus(1);
    checkOutput("rr_gap3", {14'd0, gntDc1, gntMon1}, 16'b00);
    applyStimulus(1);
    checkOutput("rr_g2", {14'd0, gntDc1, gntMon1}, 16'b01);
    checkOutput("rr_sel2", {13'd0, nRegSel1}, 16'd2);
    checkOutput("rr_valid1", {15'd0, rdValid1}, 16'd1);
    checkOutput("rr_owner1", {15'd0, rdOwner1}, 16'd0);
    checkOutput("rr_data1", rdData1, 16'h00A5);
    applyStimulus(3);
    checkOutput("rr_g3", {14'd0, gntDc1, gntMon1}, 16'b10);
    checkOutput("rr_owner2", {15'd0, rdOwner1}, 16'd1);
    applyStimulus(3);
    checkOutput("rr_g4", {14'd0, gntDc1, gntMon1}, 16'b01);
    reqDc = 1'b0; reqMon = 1'b0;

    $display("[TB] MON read stalled by write-back hazard");
    applyReset();
    reqMon = 1'b1; nRegMon = 3'd5; wbPend = 1'b1; nRegWb = 3'd5; wbDone = 1'b0;
    regData = 16'hC0DE;
    applyStimulus(1);
    checkOutput("haz_gnt_e1", {14'd0, gntDc1, gntMon1}, 16'b00);
    checkOutput("haz_busy_e1", {15'd0, busy1}, 16'd1);
    applyStimulus(2);
    checkOutput("haz_cnt_e3", {8'd0, hazCnt1}, 16'd2);
    checkOutput("haz_gnt_e3", {14'd0, gntDc1, gntMon1}, 16'b00);
    applyStimulus(1);
    wbDone = 1'b1;
    applyStimulus(1);
    checkOutput("haz_cnt_e5", {8'd0, hazCnt1}, 16'd4);
    checkOutput("haz_gnt_e5", {14'd0, gntDc1, gntMon1}, 16'b01);
    checkOutput("haz_sel_e5", {13'd0, nRegSel1}, 16'd5);
    wbDone = 1'b0; wbPend = 1'b0; reqMon = 1'b0;
    applyStimulus(3);
    checkOutput("haz_valid", {15'd0, rdValid1}, 16'd1);
    checkOutput("haz_owner", {15'd0, rdOwner1}, 16'd1);
    checkOutput("haz_data", rdData1, 16'hC0DE);
    checkOutput("haz_cnt_keep", {8'd0, hazCnt1}, 16'd4);

    $display("[TB] write-back completing in the request cycle");
    applyReset();
    reqMon = 1'b1; nRegMon = 3'd5; wbPend = 1'b1; nRegWb = 3'd5; wbDone = 1'b1;
    applyStimulus(1);
    checkOutput("wbd_gnt", {14'd0, gntDc1, gntMon1}, 16'b01);
    checkOutput("wbd_hazcnt", {8'd0, hazCnt1}, 16'd0);
    reqMon = 1'b0; wbPend = 1'b0; wbDone = 1'b0;
    applyStimulus(1);
    checkOutput("wbd_hazcnt2", {8'd0, hazCnt1}, 16'd0);

    $display("[TB] MUX_LAT=3 latency and reset during WAITD");
    applyReset();
    reqDc = 1'b1; nRegDc = 3'd6; regData = 16'h5A5A;
    applyStimulus(1);
    checkOutput("l3_gnt", {14'd0, gntDc3, gntMon3}, 16'b10);
    reqDc = 1'b0;
    applyStimulus(4);
    checkOutput("l3_valid_t5", {15'd0, rdValid3}, 16'd0);
    applyStimulus(1);
    checkOutput("l3_valid_t6", {15'd0, rdValid3}, 16'd1);
    checkOutput("l3_data_t6", rdData3, 16'h5A5A);
    reqDc = 1'b1; nRegDc = 3'd2;
    applyStimulus(1);
    checkOutput("l3_gnt2", {14'd0, gntDc3, gntMon3}, 16'b10);
    reqDc = 1'b0;
    applyStimulus(1);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("mrst_data", rdData3, 16'h0000);
    checkOutput("mrst_sel", {13'd0, nRegSel3}, 16'd0);
    checkOutput("mrst_busy", {15'd0, busy3}, 16'd0);
    checkOutput("mrst_valid", {15'd0, rdValid3}, 16'd0);
    checkOutput("mrst_owner", {15'd0, rdOwner3}, 16'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkOutput("mrst_quiet", {13'd0, rdValid3, gntDc3, gntMon3}, 16'd0);
    end

    $display("[TB] HAZ_CNT saturation");
    applyReset();
    reqDc = 1'b1; nRegDc = 3'd7; wbPend = 1'b1; nRegWb = 3'd7;
    applyStimulus(260);
    checkOutput("sat_cnt", {8'd0, hazCnt1}, 16'd255);
    checkOutput("sat_gnt", {14'd0, gntDc1, gntMon1}, 16'b00);
    wbPend = 1'b0;
    applyStimulus(1);
    checkOutput("sat_exit_gnt", {14'd0, gntDc1, gntMon1}, 16'b10);
    checkOutput("sat_exit_cnt", {8'd0, hazCnt1}, 16'd255);
    reqDc = 1'b0;
    applyStimulus(4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
